// File: rtl/pc_sequencer.sv
// PC sequencer with a circular return-address stack; pc updates one cycle after the request edge.
// en=0 stalls everything except errClr; no input reaches pc combinationally.
module pc_sequencer #(
  parameter int              WIDTH     = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         jalEN,
  input  logic                         retEN,
  input  logic                         jumpEN,
  input  logic                         branchEN,
  input  logic [WIDTH-1:0]             src2,
  input  logic                         errClr,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             Rlink,
  output logic                         linkValid,
  output logic [$clog2(RAS_DEPTH):0]   rasCount,
  output logic                         rasFull,
  output logic                         rasEmpty,
  output logic                         rasOverflow,
  output logic                         rasUnderflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] PC_ONE   = WIDTH'(1);
  localparam logic [PW-1:0]    SP_ONE   = PW'(1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] rlink_q, rlink_d;
  logic             link_vld_q, link_vld_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [PW-1:0]    top_idx;
  logic             push, ovf_evt, unf_evt, full, empty;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign pc_inc  = pc_q + PC_ONE;
  // sp_q points at the next free slot, so the top entry sits just below it.
  assign top_idx = sp_q - SP_ONE;

  always_comb begin
    pc_d       = pc_q;
    rlink_d    = rlink_q;
    link_vld_d = 1'b0;
    sp_d       = sp_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    if (en) begin
      if (jalEN) begin
        pc_d       = src2;
        rlink_d    = pc_inc;
        link_vld_d = 1'b1;
        push       = 1'b1;
        sp_d       = sp_q + SP_ONE;
        // When full, the write pointer already aliases the oldest entry.
        if (full) ovf_evt = 1'b1;
        else      cnt_d   = cnt_q + CNT_ONE;
      end else if (retEN) begin
        if (empty) begin
          pc_d    = pc_inc;
          unf_evt = 1'b1;
        end else begin
          pc_d  = ras_q[top_idx];
          sp_d  = top_idx;
          cnt_d = cnt_q - CNT_ONE;
        end
      end else if (jumpEN) begin
        pc_d = src2;
      end else if (branchEN) begin
        pc_d = pc_q + src2;
      end else begin
        pc_d = pc_inc;
      end
    end
    ovf_d = (ovf_q & ~errClr) | ovf_evt;
    unf_d = (unf_q & ~errClr) | unf_evt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      rlink_q    <= '0;
      link_vld_q <= 1'b0;
      sp_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rlink_q    <= rlink_d;
      link_vld_q <= link_vld_d;
      sp_q       <= sp_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ras_q[sp_q] <= pc_inc;
  end

  assign pc           = pc_q;
  assign Rlink        = rlink_q;
  assign linkValid    = link_vld_q;
  assign rasCount     = cnt_q;
  assign rasFull      = full;
  assign rasEmpty     = empty;
  assign rasOverflow  = ovf_q;
  assign rasUnderflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer at default parameters (WIDTH=16, RAS_DEPTH=4, RESET_PC=0).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, jalEN, retEN, jumpEN, branchEN, errClr;
  logic [15:0] src2;
  logic [15:0] pc, Rlink;
  logic        linkValid;
  logic [2:0]  rasCount;
  logic        rasFull, rasEmpty, rasOverflow, rasUnderflow;

  int n_cmp = 0;
  int n_bad = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .jalEN(jalEN), .retEN(retEN),
    .jumpEN(jumpEN), .branchEN(branchEN), .src2(src2), .errClr(errClr),
    .pc(pc), .Rlink(Rlink), .linkValid(linkValid), .rasCount(rasCount),
    .rasFull(rasFull), .rasEmpty(rasEmpty), .rasOverflow(rasOverflow),
    .rasUnderflow(rasUnderflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en = 1'b1; jalEN = 1'b0; retEN = 1'b0; jumpEN = 1'b0; branchEN = 1'b0;
    errClr = 1'b0; src2 = 16'h0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jal(input logic [15:0] tgt);
    idle(); jalEN = 1'b1; src2 = tgt; step();
  endtask

  task automatic do_ret();
    idle(); retEN = 1'b1; step();
  endtask

  task automatic do_jump(input logic [15:0] tgt);
    idle(); jumpEN = 1'b1; src2 = tgt; step();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    #12;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_cnt", rasCount, 32'h0);
    check_eq("rst_empty", rasEmpty, 32'h1);
    check_eq("rst_flags", {rasOverflow, rasUnderflow, linkValid}, 32'h0);
    check_eq("rst_rlink", Rlink, 32'h0);
    step();
    reset = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      idle(); step();
      check_eq("seq_pc", pc, 32'(i));
      check_eq("seq_empty", rasEmpty, 32'h1);
    end

    do_jump(16'h0010);
    check_eq("jump_pc", pc, 32'h0010);
    do_jal(16'h0100);
    check_eq("jal_pc", pc, 32'h0100);
    check_eq("jal_rlink", Rlink, 32'h0011);
    check_eq("jal_lv", linkValid, 32'h1);
    check_eq("jal_cnt", rasCount, 32'h1);
    idle(); step();
    check_eq("lv_drop", linkValid, 32'h0);
    check_eq("rlink_hold", Rlink, 32'h0011);
    check_eq("seq_after_jal", pc, 32'h0101);
    do_ret();
    check_eq("ret_pc", pc, 32'h0011);
    check_eq("ret_cnt", rasCount, 32'h0);

    do_jump(16'h0020);
    idle(); branchEN = 1'b1; src2 = 16'hFFFC; step();
    check_eq("branch_neg", pc, 32'h001C);
    idle(); branchEN = 1'b1; src2 = 16'h0005; step();
    check_eq("branch_pos", pc, 32'h0021);
    do_jump(16'hFFFF);
    idle(); step();
    check_eq("pc_wrap", pc, 32'h0000);

    do_ret();
    check_eq("unf_pc", pc, 32'h0001);
    check_eq("unf_flag", rasUnderflow, 32'h1);
    check_eq("unf_cnt", rasCount, 32'h0);
    idle(); en = 1'b0; errClr = 1'b1; step();
    check_eq("clr_no_en", rasUnderflow, 32'h0);
    check_eq("clr_pc_hold", pc, 32'h0001);

    do_jal(16'h0010);
    do_jal(16'h0020);
    do_jal(16'h0030);
    do_jal(16'h0040);
    check_eq("full_cnt", rasCount, 32'h4);
    check_eq("full_flag", rasFull, 32'h1);
    check_eq("no_ovf_yet", rasOverflow, 32'h0);
    do_jal(16'h0050);
    check_eq("ovf_flag", rasOverflow, 32'h1);
    check_eq("ovf_cnt", rasCount, 32'h4);
    check_eq("ovf_rlink", Rlink, 32'h0041);
    do_ret(); check_eq("lifo0", pc, 32'h0041);
    do_ret(); check_eq("lifo1", pc, 32'h0031);
    do_ret(); check_eq("lifo2", pc, 32'h0021);
    do_ret(); check_eq("lifo3", pc, 32'h0011);
    check_eq("lifo_cnt", rasCount, 32'h0);
    do_ret();
    check_eq("ret5_pc", pc, 32'h0012);
    check_eq("ret5_unf", rasUnderflow, 32'h1);
    check_eq("ovf_sticky", rasOverflow, 32'h1);

    idle(); retEN = 1'b1; errClr = 1'b1; step();
    check_eq("clr_vs_evt", rasUnderflow, 32'h1);
    check_eq("clr_ovf", rasOverflow, 32'h0);
    check_eq("clr_evt_pc", pc, 32'h0013);

    do_jal(16'h0200);
    idle(); jalEN = 1'b1; retEN = 1'b1; jumpEN = 1'b1; src2 = 16'h0300; step();
    check_eq("prio_pc", pc, 32'h0300);
    check_eq("prio_cnt", rasCount, 32'h2);
    check_eq("prio_rlink", Rlink, 32'h0201);

    idle(); en = 1'b0; jalEN = 1'b1; src2 = 16'h0400; step();
    check_eq("stall_pc", pc, 32'h0300);
    check_eq("stall_cnt", rasCount, 32'h2);
    check_eq("stall_lv", linkValid, 32'h0);
    check_eq("stall_rlink", Rlink, 32'h0201);
    do_ret();
    check_eq("ret_after_stall", pc, 32'h0201);
    check_eq("ret_after_cnt", rasCount, 32'h1);

    idle(); step();
    #2 reset = 1'b0;
    #1;
    check_eq("async_pc", pc, 32'h0);
    check_eq("async_cnt", rasCount, 32'h0);
    check_eq("async_flags", {rasOverflow, rasUnderflow, linkValid}, 32'h0);
    check_eq("async_rlink", Rlink, 32'h0);
    step();
    reset = 1'b1;
    do_ret();
    check_eq("post_rst_pc", pc, 32'h0001);
    check_eq("post_rst_unf", rasUnderflow, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
